// File: rtl/apb_mem_slave_param_pkg.sv
// Shared types and helpers for the parametrised APB-to-memory slave.
// Holds the FSM state encoding, the memory address width rule and the decode function.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int MEM_AW_MIN = 1;

  // A one-word window still needs a 1-bit address port.
  function automatic int mem_aw(input int depth);
    int w;
    w = $clog2(depth);
    return (w < MEM_AW_MIN) ? MEM_AW_MIN : w;
  endfunction

  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth);
    return (addr >= base) && (addr < (base + depth));
  endfunction

endpackage

// File: rtl/apb_mem_slave_param_if.sv
// APB bus bundle between the master/interconnect and the memory slave.
interface apb_mem_slave_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Fixed wait-state down-counter followed by a ready-timeout up-counter.
// done: wait states exhausted; timeout: last permitted not-ready cycle reached.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] wait_val,
  input  logic       ready,
  output logic       done,
  output logic       timeout
);
  localparam int           TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit           TO_EN   = (TIMEOUT > 0);
  localparam logic [TW-1:0] TC_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [3:0]    wcnt;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
      tcnt <= '0;
    end else if (load) begin
      wcnt <= wait_val;
      tcnt <= '0;
    end else if (run) begin
      if (wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end else if (!ready) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  assign done    = run && (wcnt == 4'd0);
  assign timeout = done && !ready && TO_EN && (tcnt == TC_LAST);

endmodule

// File: rtl/apb_mem_slave_param.sv
// APB slave bridging to a synchronous memory-style sub-module bus, with
// fixed wait states, sub-module ready timeout, range decode and abort on psel drop.
//
// state | meaning
// IDLE  | waiting for a setup beat (psel=1, penable=0)
// MEM   | one-cycle chip enable and read/write strobe to the sub-module
// WAIT  | fixed wait states, then wait for mem_ready (with timeout)
// RESP  | pready high for one cycle, then back to IDLE
module apb_mem_slave_param
  import apb_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int BASE_ADDR     = 0,
  parameter int MEM_DEPTH     = 256,
  parameter int WAIT_STATES   = 0,
  parameter int USE_SUB_READY = 1,
  parameter int TIMEOUT       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  apb_mem_slave_param_if.slave             apb,
  output logic                             mem_ce,
  output logic                             mem_rden,
  output logic                             mem_wren,
  output logic [mem_aw(MEM_DEPTH)-1:0]     mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_ready
);
  localparam int MEM_AW = mem_aw(MEM_DEPTH);

  state_t              state, state_nx;
  logic                wr_q, wr_nx;
  logic                pready_q, pready_nx;
  logic                pslverr_q, pslverr_nx;
  logic [DATA_W-1:0]   prdata_q, prdata_nx;
  logic                ce_nx, rden_nx, wren_nx;
  logic [MEM_AW-1:0]   maddr_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic [ADDR_W-1:0]   addr_off;
  logic                hit;
  logic                ready_eff;
  logic                wait_done;
  logic                wait_timeout;

  assign addr_off  = apb.paddr - ADDR_W'(BASE_ADDR);
  assign hit       = in_range(64'(apb.paddr), 64'(BASE_ADDR), 64'(MEM_DEPTH));
  assign ready_eff = mem_ready || (USE_SUB_READY == 0);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == MEM),
    .run      (state == WAIT),
    .wait_val (4'(WAIT_STATES)),
    .ready    (ready_eff),
    .done     (wait_done),
    .timeout  (wait_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      mem_ce    <= 1'b0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      wr_q      <= wr_nx;
      pready_q  <= pready_nx;
      pslverr_q <= pslverr_nx;
      prdata_q  <= prdata_nx;
      mem_ce    <= ce_nx;
      mem_rden  <= rden_nx;
      mem_wren  <= wren_nx;
      mem_addr  <= maddr_nx;
      mem_wdata <= wdata_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    wr_nx      = wr_q;
    pready_nx  = 1'b0;
    pslverr_nx = 1'b0;
    prdata_nx  = '0;
    ce_nx      = 1'b0;
    rden_nx    = 1'b0;
    wren_nx    = 1'b0;
    maddr_nx   = mem_addr;
    wdata_nx   = mem_wdata;
    case (state)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          wr_nx    = apb.pwrite;
          maddr_nx = MEM_AW'(addr_off);
          wdata_nx = apb.pwdata;
          if (hit) begin
            state_nx = MEM;
            ce_nx    = 1'b1;
            wren_nx  = apb.pwrite;
            rden_nx  = !apb.pwrite;
          end else begin
            // Out-of-window: zero-wait error, sub-module never touched.
            state_nx   = RESP;
            pready_nx  = 1'b1;
            pslverr_nx = 1'b1;
          end
        end
      end
      MEM: begin
        state_nx = apb.psel ? WAIT : IDLE;
      end
      WAIT: begin
        if (!apb.psel) begin
          state_nx = IDLE;
        end else if (wait_done && ready_eff) begin
          state_nx  = RESP;
          pready_nx = 1'b1;
          prdata_nx = wr_q ? '0 : mem_rdata;
        end else if (wait_timeout) begin
          state_nx   = RESP;
          pready_nx  = 1'b1;
          pslverr_nx = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Directed bench for apb_mem_slave_param: two configurations share one APB stimulus,
// a transaction-level model predicts completion cycle, error and read data per transfer.
module tb_apb_mem_slave_param;

  logic clk;
  logic reset;
  logic psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic mem_ready;
  bit   sel;

  int cyc;
  int nvec;
  int nerr;

  // config A: base 0, depth 256, no wait states, timeout 16
  // config B: base 16, depth 8, 3 wait states, timeout 4
  apb_mem_slave_param_if #(.DATA_W(8), .ADDR_W(8)) if_a ();
  apb_mem_slave_param_if #(.DATA_W(8), .ADDR_W(8)) if_b ();

  logic       a_ce, a_rden, a_wren;
  logic [7:0] a_maddr, a_wdata, a_rdata;
  logic       b_ce, b_rden, b_wren;
  logic [2:0] b_maddr;
  logic [7:0] b_wdata, b_rdata;

  assign if_a.psel = psel;   assign if_b.psel = psel;
  assign if_a.penable = penable; assign if_b.penable = penable;
  assign if_a.pwrite = pwrite; assign if_b.pwrite = pwrite;
  assign if_a.paddr = paddr;  assign if_b.paddr = paddr;
  assign if_a.pwdata = pwdata; assign if_b.pwdata = pwdata;

  apb_mem_slave_param #(
    .DATA_W(8), .ADDR_W(8), .BASE_ADDR(0), .MEM_DEPTH(256),
    .WAIT_STATES(0), .USE_SUB_READY(1), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .reset(reset), .apb(if_a.slave),
    .mem_ce(a_ce), .mem_rden(a_rden), .mem_wren(a_wren),
    .mem_addr(a_maddr), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata), .mem_ready(mem_ready)
  );

  apb_mem_slave_param #(
    .DATA_W(8), .ADDR_W(8), .BASE_ADDR(16), .MEM_DEPTH(8),
    .WAIT_STATES(3), .USE_SUB_READY(1), .TIMEOUT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .apb(if_b.slave),
    .mem_ce(b_ce), .mem_rden(b_rden), .mem_wren(b_wren),
    .mem_addr(b_maddr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sub-module memories: read data registered one cycle after the strobe.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [8];
  always @(posedge clk) begin
    if (a_wren) mem_a[a_maddr] <= a_wdata;
    if (a_rden) a_rdata <= mem_a[a_maddr];
    if (b_wren) mem_b[b_maddr] <= b_wdata;
    if (b_rden) b_rdata <= mem_b[b_maddr];
  end

  // Reference contents and per-transfer expectations.
  logic [7:0] sh_a [256];
  logic [7:0] sh_b [8];
  int exp_c0, exp_resp, exp_err, exp_rdata, exp_maddr, exp_wdata;
  bit exp_w;
  int obs_resp, obs_err, obs_rdata, obs_maddr;

  logic       pready_s, pslverr_s, ce_s, wren_s, rden_s;
  logic [7:0] prdata_s, maddr_s, wdata_s;
  always_comb begin
    pready_s  = sel ? if_b.pready  : if_a.pready;
    pslverr_s = sel ? if_b.pslverr : if_a.pslverr;
    prdata_s  = sel ? if_b.prdata  : if_a.prdata;
    ce_s      = sel ? b_ce   : a_ce;
    wren_s    = sel ? b_wren : a_wren;
    rden_s    = sel ? b_rden : a_rden;
    maddr_s   = sel ? {5'd0, b_maddr} : a_maddr;
    wdata_s   = sel ? b_wdata : a_wdata;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("pready",   32'(pready_s),  32'(cyc == exp_resp));
      chk("pslverr",  32'(pslverr_s), (cyc == exp_resp) ? 32'(exp_err) : 32'd0);
      chk("prdata",   32'(prdata_s),  (cyc == exp_resp) ? 32'(exp_rdata) : 32'd0);
      chk("mem_ce",   32'(ce_s),      32'(cyc == exp_c0));
      chk("mem_wren", 32'(wren_s),    32'(cyc == exp_c0 && exp_w));
      chk("mem_rden", 32'(rden_s),    32'(cyc == exp_c0 && !exp_w));
      if (cyc == exp_c0) begin
        chk("mem_addr", 32'(maddr_s), 32'(exp_maddr));
        if (exp_w) chk("mem_wdata", 32'(wdata_s), 32'(exp_wdata));
      end
      if (pready_s && obs_resp < 0) begin
        obs_resp  = cyc;
        obs_err   = 32'(pslverr_s);
        obs_rdata = 32'(prdata_s);
      end
      if (ce_s) obs_maddr = 32'(maddr_s);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One APB transfer starting now (#1 after an edge). rl = number of ready checks
  // that see mem_ready low; abort_at/rst_at = cycles after setup to drop psel / pulse reset.
  task automatic xfer(input bit w, input int addr, input int data, input int rl,
                      input int abort_at, input int rst_at,
                      output int lat, output int err, output int rd);
    int c0, ws, to, base, depth, rdy_at, stop;
    bit inr;
    ws    = sel ? 3 : 0;
    to    = sel ? 4 : 16;
    base  = sel ? 16 : 0;
    depth = sel ? 8 : 256;
    inr   = (addr >= base) && (addr < base + depth);
    c0    = cyc + 1;
    psel = 1'b1; penable = 1'b0; pwrite = w;
    paddr = addr[7:0]; pwdata = data[7:0];
    mem_ready = (rl == 0);
    obs_resp = -1; obs_err = -1; obs_rdata = -1; obs_maddr = -1;
    exp_c0 = inr ? c0 : -1;
    exp_w = w; exp_maddr = addr - base; exp_wdata = data;
    if (!inr) begin
      exp_resp = c0; exp_err = 1; exp_rdata = 0;
    end else if (to > 0 && rl >= to) begin
      exp_resp = c0 + 2 + ws + to - 1; exp_err = 1; exp_rdata = 0;
    end else begin
      exp_resp = c0 + 2 + ws + rl; exp_err = 0;
      exp_rdata = w ? 0 : 32'(sel ? sh_b[addr - base] : sh_a[addr - base]);
    end
    if (inr && w) begin
      if (sel) sh_b[addr - base] = data[7:0];
      else     sh_a[addr - base] = data[7:0];
    end
    rdy_at = c0 + 1 + ws + rl;
    stop = exp_resp + 1;
    if (abort_at > 0) stop = c0 + abort_at + 1;
    if (rst_at > 0)   stop = c0 + rst_at + 1;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = ~paddr;
    pwdata = ~pwdata;
    while (cyc < stop) begin
      if (cyc == rdy_at) mem_ready = 1'b1;
      if (abort_at > 0 && cyc == c0 + abort_at) begin
        psel = 1'b0; penable = 1'b0; exp_resp = -1;
      end
      if (rst_at > 0 && cyc == c0 + rst_at) begin
        reset = 1'b1; exp_resp = -1;
      end
      @(posedge clk); #1;
    end
    lat = (obs_resp < 0) ? -1 : obs_resp - c0;
    err = obs_err;
    rd  = obs_rdata;
    if (rst_at > 0) begin
      chk("rst_pready",  32'(pready_s), 32'd0);
      chk("rst_ce",      32'(ce_s), 32'd0);
      chk("rst_maddr",   32'(maddr_s), 32'd0);
      chk("rst_wdata",   32'(wdata_s), 32'd0);
    end
    psel = 1'b0; penable = 1'b0; reset = 1'b0; mem_ready = 1'b1;
  endtask

  int lat, err, rd;

  initial begin
    cyc = 0; nvec = 0; nerr = 0;
    reset = 1'b1; sel = 1'b0; mem_ready = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    exp_c0 = -1; exp_resp = -1; exp_err = 0; exp_rdata = 0; exp_w = 1'b0;
    exp_maddr = 0; exp_wdata = 0;
    obs_resp = -1; obs_err = -1; obs_rdata = -1; obs_maddr = -1;
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; sh_a[i] = '0; end
    for (int i = 0; i < 8; i++) begin mem_b[i] = '0; sh_b[i] = '0; end
    a_rdata = '0; b_rdata = '0;
    idle(3);
    reset = 1'b0;
    chk("reset_maddr_a", 32'(a_maddr), 32'd0);
    chk("reset_maddr_b", 32'(b_maddr), 32'd0);

    // Config A: zero wait states
    xfer(1'b1, 6, 5, 0, 0, 0, lat, err, rd);
    chk("t1_lat", lat, 2); chk("t1_err", err, 0); chk("t1_maddr", obs_maddr, 6);
    xfer(1'b0, 6, 0, 0, 0, 0, lat, err, rd);
    chk("t2_lat", lat, 2); chk("t2_rdata", rd, 5);
    xfer(1'b1, 5, 4, 5, 0, 0, lat, err, rd);
    chk("t3w_lat", lat, 7); chk("t3w_err", err, 0);
    xfer(1'b0, 5, 0, 5, 0, 0, lat, err, rd);
    chk("t3r_lat", lat, 7); chk("t3r_rdata", rd, 4);
    xfer(1'b1, 255, 'hA5, 0, 0, 0, lat, err, rd);
    xfer(1'b0, 255, 0, 0, 0, 0, lat, err, rd);
    chk("top_rdata", rd, 'hA5);
    idle(2);

    // Config B: base 16, depth 8, 3 wait states, timeout 4
    sel = 1'b1;
    xfer(1'b0, 16, 0, 0, 0, 0, lat, err, rd);
    chk("t4r_lat", lat, 5); chk("t4r_rdata", rd, 0);
    xfer(1'b1, 16, 'h3C, 0, 0, 0, lat, err, rd);
    chk("t4w_lat", lat, 5);
    xfer(1'b0, 16, 0, 0, 0, 0, lat, err, rd);
    chk("t4rb_rdata", rd, 'h3C);
    xfer(1'b0, 24, 0, 0, 0, 0, lat, err, rd);
    chk("t5_oor_lat", lat, 0); chk("t5_oor_err", err, 1); chk("t5_oor_ce", obs_maddr, -1);
    xfer(1'b1, 15, 'h11, 0, 0, 0, lat, err, rd);
    chk("t5_low_err", err, 1);
    xfer(1'b1, 23, 'h77, 0, 0, 0, lat, err, rd);
    chk("t5_top_lat", lat, 5); chk("t5_top_maddr", obs_maddr, 7);
    xfer(1'b0, 23, 0, 0, 0, 0, lat, err, rd);
    chk("t5_top_rdata", rd, 'h77);
    xfer(1'b0, 17, 0, 99, 0, 0, lat, err, rd);
    chk("t6_to_lat", lat, 8); chk("t6_to_err", err, 1); chk("t6_to_rdata", rd, 0);
    xfer(1'b0, 17, 'h5A, 99, 0, 4, lat, err, rd);
    chk("t6_rst_lat", lat, -1);
    idle(2);
    xfer(1'b1, 18, 'h42, 99, 3, 0, lat, err, rd);
    chk("t6_abort_lat", lat, -1);
    idle(3);
    xfer(1'b0, 18, 0, 0, 0, 0, lat, err, rd);
    chk("after_abort_lat", lat, 5); chk("after_abort_rdata", rd, 'h42);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_param.md
Name: apb_mem_slave_param

Overview:
Parametrised next-generation APB slave bridging the APB bus to a synchronous memory-style sub-module bus.
Generalised in data/address width, base address and memory depth.
Adds behaviour the current slave lacks: a programmable fixed wait-state count, a sub-module-ready timeout, address-range decode with PSLVERR, and abort on a protocol violation.
Sits between the APB master/interconnect and one memory or peripheral sub-module.

Parameters:
DATA_W, 8, APB and memory data width (8..32)
ADDR_W, 8, APB address width
BASE_ADDR, 0, first APB address mapped to this slave
MEM_DEPTH, 256, number of words in the memory window; must satisfy BASE_ADDR+MEM_DEPTH <= 2**ADDR_W
WAIT_STATES, 0, fixed extra wait cycles inserted before sub-module ready is checked (0..15)
USE_SUB_READY, 1, 1 = completion also requires mem_ready; 0 = mem_ready ignored
TIMEOUT, 16, cycles to wait for mem_ready after the fixed waits expire before an error response; 0 disables the timeout

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  APB address
pwdata  in  DATA_W  APB write data
prdata  out  DATA_W  APB read data, registered
pready  out  1  APB ready, registered
pslverr  out  1  APB error, valid only while pready=1
mem_ce  out  1  sub-module chip enable
mem_rden  out  1  sub-module read strobe
mem_wren  out  1  sub-module write strobe
mem_addr  out  $clog2(MEM_DEPTH)  local address, paddr-BASE_ADDR
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; valid the cycle after mem_rden
mem_ready  in  1  sub-module ready

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0. A reset asserted mid-transfer takes effect at the next edge; no pready is issued for the interrupted transfer.
- States: IDLE, MEM, WAIT, RESP.
- IDLE: on an edge sampling psel=1 and penable=0, latch pwrite, paddr and pwdata.
  - In range (BASE_ADDR <= paddr < BASE_ADDR+MEM_DEPTH): go to MEM; mem_ce=1; mem_wren=pwrite; mem_rden=!pwrite; drive mem_addr and mem_wdata.
  - Out of range: go straight to RESP with pready=1, pslverr=1, prdata=0. This is a zero-wait error completing on the first penable edge. No mem strobes are issued.
- MEM: exactly one cycle. Strobes return to 0 at the next edge. Load wait counter with WAIT_STATES and clear the timeout timer. Go to WAIT.
- WAIT: if wait count != 0, decrement it.
  - Otherwise, if mem_ready=1 or USE_SUB_READY=0: go to RESP with pready=1 and pslverr=0. On a read, prdata is captured from mem_rdata.
  - Otherwise increment the timer. When timer == TIMEOUT-1 (TIMEOUT>0), go to RESP with pready=1, pslverr=1, prdata=0.
- RESP: pready is high for exactly one cycle. Return to IDLE; pready, pslverr and prdata return to 0.
- Minimum in-range latency: setup edge E0, pready high E2–E3, master samples completion at E3. Each WAIT_STATES count adds 1 cycle; each cycle with mem_ready low adds 1 cycle.
- Abort: if psel is sampled 0 in MEM or WAIT, go to IDLE with no pready. A write strobe already issued is not undone.
- penable sampled 0 in WAIT does not abort; the slave simply waits.
- pwdata and paddr changes after setup are ignored; the latched values are used.
- Back-to-back transfers: a new setup beat sampled in the cycle after RESP is accepted normally.
- mem_addr width is $clog2(MEM_DEPTH) with a minimum of 1; subtraction is done at ADDR_W and then truncated.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, MEM, WAIT, RESP);
  - the localparam for the mem address width;
  - the in_range() function.
- Sub-module apb_wait_timer holds the combined wait-state down-counter and timeout up-counter.
  - Inputs: load, wait value, ready.
  - Outputs: done, timeout.

Test Plan:
1. WAIT_STATES=0, mem_ready=1: write addr 6 data 5 -> one mem_wren pulse at addr 6; pready high 1 cycle at E2; pslverr=0.
2. Read addr 6 -> mem_rden pulse; prdata=5 during the pready cycle; prdata=0 afterwards.
3. Hold mem_ready=0 for 5 cycles, write 4 to addr 5, then read it back -> pready delayed by 5 cycles for each transfer; readback prdata=4.
4. WAIT_STATES=3, mem_ready=1: read -> pready at E5; same latency for a write.
5. BASE_ADDR=16, MEM_DEPTH=8: access addr 24 -> pready on the first penable edge, pslverr=1, no mem_ce pulse. Access addr 23 -> normal completion with mem_addr=7.
6. TIMEOUT=4 with mem_ready stuck at 0 -> pready with pslverr=1 after 4 wait cycles. Repeat with reset asserted mid-WAIT -> all outputs 0 next cycle, no pready. Repeat with psel dropped mid-WAIT -> abort to IDLE.
